lsu_rmw: RTL and testbench

Load/store initiator between the CPU datapath and the word-wide data port of `uniform_memory`. It accepts one MIPS load/store request at a time and issues word-aligned transactions over `memory_interface`. Sub-word stores become read-modify-write sequences, and sub-word loads are extracted and extended. Misaligned accesses are reported as faults and never reach memory.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/memory_interface.sv | 16 +
 rtl/lsu_lane_unit.sv | 60 ++++++
 rtl/lsu_rmw.sv | 162 ++++++++++++++++
 tb/tb_lsu_rmw.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the lsu_rmw load/store initiator.
//   mem_op_t      - CPU load/store operation encoding
//   lsu_state_t   - sequencing states of the initiator
//   is_store      - op writes memory
//   is_misaligned - op/address combination that must fault instead of issuing
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    logic res;
    case (op)
      OP_SB, OP_SH, OP_SW: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  // Only the two low address bits decide alignment; byte ops are always aligned.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
    logic res;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = addr_lo[0];
      OP_LW, OP_SW:         res = (addr_lo != 2'b00);
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/memory_interface.sv
// memory_interface: word-wide port of uniform_memory.
//   addr  - word-aligned byte address (master)
//   din   - write data (master)
//   write - write strobe, commits on a clock edge with busy low (master)
//   dout  - read data, combinational from addr (slave)
//   busy  - memory stall; master holds its request while high (slave)
interface memory_interface;
  logic [31:0] addr;
  logic [31:0] din;
  logic        write;
  logic [31:0] dout;
  logic        busy;

  modport master (output addr, output din, output write, input dout, input busy);
  modport slave  (input addr, input din, input write, output dout, output busy);
endinterface

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: combinational byte/half lane logic for lsu_rmw.
//   op        - operation being executed
//   addr_lo   - low two bits of the byte address
//   rdata     - word read from memory
//   wdata     - store data (sub-word value in the low bits)
//   load_data - extracted and sign/zero-extended load result
//   merged    - read word with the store lane replaced (SB/SH)
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [1:0]  byte_lane_s;
  logic        half_lane_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Physical lane selection; big-endian mirrors the lane order inside the word.
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_lane_s = ~addr_lo;
      half_lane_s = ~addr_lo[1];
    end else begin
      byte_lane_s = addr_lo;
      half_lane_s = addr_lo[1];
    end
  end

  // Load extraction and extension.
  always_comb begin
    byte_s = rdata[{byte_lane_s, 3'b000} +: 8];
    half_s = rdata[{half_lane_s, 4'b0000} +: 16];
    case (op)
      OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_data = {24'h00_0000, byte_s};
      OP_LH:   load_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_data = {16'h0000, half_s};
      default: load_data = rdata;
    endcase
  end

  // Store merge: untouched lanes come from the word just read.
  always_comb begin
    merged = rdata;
    case (op)
      OP_SB:   merged[{byte_lane_s, 3'b000} +: 8]   = wdata[7:0];
      OP_SH:   merged[{half_lane_s, 4'b0000} +: 16] = wdata;
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: single-outstanding load/store initiator with read-modify-write
// for sub-word stores and fault reporting for misaligned accesses.
//   clk, reset        - clock, synchronous active-high reset
//   req_valid/ready   - CPU request handshake (ready only in IDLE)
//   req_op/addr/wdata - operation, byte address, store data
//   resp_valid        - one-cycle completion pulse
//   resp_rdata        - load result, held until the next load response
//   resp_fault        - misaligned access (no memory cycle issued)
//   resp_fault_store  - faulting op was a store
//   mem               - word-wide memory port (master side)
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  mem_op_t         req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            resp_fault,
  output logic            resp_fault_store,
  memory_interface.master mem
);

  lsu_state_t  state_r;
  mem_op_t     op_r;
  logic [1:0]  addr_lo_r;
  logic [15:0] wdata_lo_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_fault_r;
  logic        resp_fault_store_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_din_r;
  logic        mem_write_r;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  lsu_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .op        (op_r),
    .addr_lo   (addr_lo_r),
    .rdata     (mem.dout),
    .wdata     (wdata_lo_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // Request sequencing; every output is registered and updated on the
  // transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= S_IDLE;
      op_r               <= OP_LB;
      addr_lo_r          <= 2'b00;
      wdata_lo_r         <= 16'h0000;
      req_ready_r        <= 1'b1;
      resp_valid_r       <= 1'b0;
      resp_rdata_r       <= 32'h0000_0000;
      resp_fault_r       <= 1'b0;
      resp_fault_store_r <= 1'b0;
      mem_addr_r         <= 32'h0000_0000;
      mem_din_r          <= 32'h0000_0000;
      mem_write_r        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready_r) begin
            op_r        <= req_op;
            addr_lo_r   <= req_addr[1:0];
            wdata_lo_r  <= req_wdata[15:0];
            req_ready_r <= 1'b0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              // Fault: answer directly, memory port stays idle, rdata untouched.
              state_r            <= S_RESP;
              resp_valid_r       <= 1'b1;
              resp_fault_r       <= 1'b1;
              resp_fault_store_r <= is_store(req_op);
            end else if (req_op == OP_SW) begin
              state_r     <= S_WR;
              mem_addr_r  <= {req_addr[31:2], 2'b00};
              mem_din_r   <= req_wdata;
              mem_write_r <= 1'b1;
            end else begin
              // Loads and sub-word stores both start with a read.
              state_r     <= S_RD;
              mem_addr_r  <= {req_addr[31:2], 2'b00};
              mem_din_r   <= 32'h0000_0000;
              mem_write_r <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RD: begin
          if (!mem.busy) begin
            if (is_store(op_r)) begin
              state_r     <= S_WR;
              mem_din_r   <= merged_s;
              mem_write_r <= 1'b1;
            end else begin
              state_r            <= S_RESP;
              resp_valid_r       <= 1'b1;
              resp_rdata_r       <= load_data_s;
              resp_fault_r       <= 1'b0;
              resp_fault_store_r <= 1'b0;
              mem_addr_r         <= 32'h0000_0000;
            end
          end else begin
            state_r <= S_RD;
          end
        end
        S_WR: begin
          // addr/din/write are only touched when the write commits.
          if (!mem.busy) begin
            state_r            <= S_RESP;
            resp_valid_r       <= 1'b1;
            resp_fault_r       <= 1'b0;
            resp_fault_store_r <= 1'b0;
            mem_addr_r         <= 32'h0000_0000;
            mem_din_r          <= 32'h0000_0000;
            mem_write_r        <= 1'b0;
          end else begin
            state_r <= S_WR;
          end
        end
        S_RESP: begin
          state_r            <= S_IDLE;
          req_ready_r        <= 1'b1;
          resp_valid_r       <= 1'b0;
          resp_fault_r       <= 1'b0;
          resp_fault_store_r <= 1'b0;
        end
        default: begin
          state_r            <= S_IDLE;
          req_ready_r        <= 1'b1;
          resp_valid_r       <= 1'b0;
          resp_fault_r       <= 1'b0;
          resp_fault_store_r <= 1'b0;
          mem_addr_r         <= 32'h0000_0000;
          mem_din_r          <= 32'h0000_0000;
          mem_write_r        <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_r;
  assign resp_valid       = resp_valid_r;
  assign resp_rdata       = resp_rdata_r;
  assign resp_fault       = resp_fault_r;
  assign resp_fault_store = resp_fault_store_r;
  assign mem.addr         = mem_addr_r;
  assign mem.din          = mem_din_r;
  assign mem.write        = mem_write_r;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: scoreboard bench for lsu_rmw with a word memory model on the
// memory port and a byte-arithmetic reference model of the load/store rules.
module tb_lsu_rmw;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    bit          f;
    bit          fs;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_fault_store;

  memory_interface mif ();

  lsu_rmw #(.BIG_ENDIAN(1'b0)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .resp_fault_store (resp_fault_store),
    .mem              (mif)
  );

  // Memory attached to the DUT (addresses 0x1000_0000..0x1000_03FF)
  logic [31:0] dmem [0:255];
  // Reference model memory
  logic [31:0] rmem [0:255];
  logic [31:0] last_rd;
  exp_t        sb [$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          busy_force = 1'b0;
  bit          busy_rand_en = 1'b0;
  logic        busy_rnd = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) busy_rnd <= busy_rand_en && ($urandom_range(0, 3) == 0);

  assign mif.busy = busy_force | busy_rnd;
  assign mif.dout = dmem[mif.addr[9:2]];

  always @(posedge clk) begin
    if (!reset && mif.write && !mif.busy) dmem[mif.addr[9:2]] <= mif.din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte/halfword arithmetic on a word array.
  task automatic model(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int idx;
    int unsigned w, b, h, bsh, hsh;
    bit is_h, is_w, st;
    idx  = int'(a[9:2]);
    w    = rmem[idx];
    bsh  = 8 * (a % 4);
    hsh  = 16 * ((a / 2) % 2);
    b    = (w >> bsh) & 32'hFF;
    h    = (w >> hsh) & 32'hFFFF;
    is_h = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    is_w = (op == OP_LW) || (op == OP_SW);
    st   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    e.f  = (is_h && (a % 2 != 0)) || (is_w && (a % 4 != 0));
    e.fs = e.f && st;
    e.chk_rd = e.f || !st;
    e.rd = last_rd;
    if (!e.f) begin
      case (op)
        OP_LB:   e.rd = (b >= 128) ? 32'(int'(b) - 256) : b;
        OP_LBU:  e.rd = b;
        OP_LH:   e.rd = (h >= 32768) ? 32'(int'(h) - 65536) : h;
        OP_LHU:  e.rd = h;
        OP_LW:   e.rd = w;
        OP_SB:   rmem[idx] = (w & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
        OP_SH:   rmem[idx] = (w & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
        default: rmem[idx] = wd;
      endcase
      if (!st) last_rd = e.rd;
    end
  endtask

  // Drive one request; returns at the falling edge of the cycle after acceptance.
  task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input bit push);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    if (push) begin
      model(op, a, wd, e);
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: compare every response against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, mon_e.f});
        if (mon_e.f) chk("resp_fault_store", {31'd0, resp_fault_store}, {31'd0, mon_e.fs});
        if (mon_e.chk_rd) chk("resp_rdata", resp_rdata, mon_e.rd);
        if (mon_e.lat >= 0) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   guard;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      dmem[i] <= (32'h9E37_79B9 * i) ^ 32'h5A5A_0F0F;
      rmem[i]  = (32'h9E37_79B9 * i) ^ 32'h5A5A_0F0F;
    end
    dmem[64] <= 32'h8899_AABB;
    rmem[64]  = 32'h8899_AABB;
    last_rd   = 32'h0000_0000;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_LB;
    req_addr  = 32'h0000_0000;
    req_wdata = 32'h0000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0000_0000);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_mem_write", {31'd0, mif.write}, 32'd0);
    chk("rst_mem_addr", mif.addr, 32'h0000_0000);
    chk("rst_mem_din", mif.din, 32'h0000_0000);

    // Sub-word loads
    issue(OP_LB,  32'h1000_0101, 32'h0, 2, 1'b1);
    issue(OP_LBU, 32'h1000_0101, 32'h0, 2, 1'b1);
    issue(OP_LH,  32'h1000_0102, 32'h0, 2, 1'b1);

    // SB read-modify-write with cycle-level port checks
    issue(OP_SB, 32'h1000_0102, 32'h0000_0055, 3, 1'b1);
    chk("sb_rd_addr", mif.addr, 32'h1000_0100);
    chk("sb_rd_write", {31'd0, mif.write}, 32'd0);
    @(negedge clk);
    chk("sb_wr_write", {31'd0, mif.write}, 32'd1);
    chk("sb_wr_din", mif.din, 32'h8855_AABB);
    chk("sb_wr_addr", mif.addr, 32'h1000_0100);
    issue(OP_LW, 32'h1000_0100, 32'h0, 2, 1'b1);

    // Misaligned accesses
    issue(OP_LW, 32'h1000_0106, 32'h0, 1, 1'b1);
    chk("fault_lw_write", {31'd0, mif.write}, 32'd0);
    chk("fault_lw_addr", mif.addr, 32'h0000_0000);
    issue(OP_SH, 32'h1000_0103, 32'h0000_1234, 1, 1'b1);
    chk("fault_sh_write", {31'd0, mif.write}, 32'd0);

    // SW with three busy cycles in WR
    busy_force = 1'b1;
    issue(OP_SW, 32'h1000_0200, 32'hDEAD_BEEF, 5, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("busy_wr_addr", mif.addr, 32'h1000_0200);
      chk("busy_wr_din", mif.din, 32'hDEAD_BEEF);
      chk("busy_wr_write", {31'd0, mif.write}, 32'd1);
      if (k == 4) busy_force = 1'b0;
      else @(negedge clk);
    end
    issue(OP_LW, 32'h1000_0200, 32'h0, 2, 1'b1);

    // Reset during the RD cycle of an SH
    issue(OP_SH, 32'h1000_0104, 32'h0000_CAFE, 0, 1'b0);
    reset   = 1'b1;
    last_rd = 32'h0000_0000;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_mem_write", {31'd0, mif.write}, 32'd0);
    issue(OP_LW, 32'h1000_0104, 32'h0, 2, 1'b1);
    issue(OP_LW, 32'h1000_0106, 32'h0, 1, 1'b1);

    // Randomized traffic, back-to-back, with random busy stalls
    busy_rand_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = 32'h1000_0000 | 32'($urandom_range(0, 1023));
      issue(mem_op_t'(3'($urandom_range(0, 7))), a, $urandom, -1, 1'b1);
    end
    busy_rand_en = 1'b0;

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
